// File: rtl/ieee_mult_stream.sv
// Streaming IEEE 754 binary multiplier with valid/ready on both sides.
// Ports: clk_i/rst_ni; in_valid_i/in_ready_o with operand_a_i, operand_b_i,
//   tag_i; out_valid_o/out_ready_i with result_o, tag_o, flags_o {NV,OF,UF,NX}.
module ieee_mult_stream #(
    parameter int unsigned ExpWidth  = 8,
    parameter int unsigned ManWidth  = 23,
    parameter int unsigned Latency   = 2,
    parameter int unsigned TagWidth  = 4,
    parameter int unsigned DataWidth = 1 + ExpWidth + ManWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] operand_a_i,
    input  logic [DataWidth-1:0] operand_b_i,
    input  logic [TagWidth-1:0]  tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] result_o,
    output logic [TagWidth-1:0]  tag_o,
    output logic [3:0]           flags_o
);

    if (Latency < 1) begin : g_bad_latency
        $error("ieee_mult_stream: Latency must be >= 1");
    end
    if (ExpWidth < 2 || ManWidth < 2 || TagWidth < 1) begin : g_bad_width
        $error("ieee_mult_stream: illegal field width");
    end

    localparam int unsigned ProdWidth = 2 * ManWidth + 2;
    localparam int unsigned EW        = ExpWidth + 2;
    localparam int unsigned Bias      = 2 ** (ExpWidth - 1) - 1;
    localparam int unsigned EMax      = 2 ** ExpWidth - 1;

    // ---------------- operand decode ----------------
    logic                sign_a, sign_b, sign_p;
    logic [ExpWidth-1:0] exp_a, exp_b;
    logic [ManWidth-1:0] man_a, man_b;

    assign {sign_a, exp_a, man_a} = operand_a_i;
    assign {sign_b, exp_b, man_b} = operand_b_i;
    assign sign_p = sign_a ^ sign_b;

    logic ones_a, ones_b;
    logic zero_a, zero_b;
    logic inf_a, inf_b;
    logic nan_a, nan_b;
    logic snan;

    assign ones_a = &exp_a;
    assign ones_b = &exp_b;
    // Subnormals flush to zero: a zero exponent field is treated as zero.
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign inf_a  = ones_a & (man_a == '0);
    assign inf_b  = ones_b & (man_b == '0);
    assign nan_a  = ones_a & (man_a != '0);
    assign nan_b  = ones_b & (man_b != '0);
    assign snan   = (nan_a & ~man_a[ManWidth-1]) | (nan_b & ~man_b[ManWidth-1]);

    // ---------------- normal path ----------------
    logic [ProdWidth-1:0] prod;
    logic [ProdWidth-2:0] norm;
    logic [ManWidth-1:0]  mant;
    logic                 guard, sticky, rnd_up;
    logic [ManWidth:0]    mant_r;
    logic [EW-1:0]        exp_sum;
    logic                 ovf, unf;

    always_comb begin
        prod = ProdWidth'({1'b1, man_a}) * ProdWidth'({1'b1, man_b});
        // Align so the leading one sits just above norm[ProdWidth-2].
        norm = prod[ProdWidth-1] ? prod[ProdWidth-2:0]
                                 : {prod[ProdWidth-3:0], 1'b0};
        mant   = norm[ProdWidth-2 -: ManWidth];
        guard  = norm[ManWidth];
        sticky = |norm[ManWidth-1:0];
        rnd_up = guard & (sticky | mant[0]);
        // A carry out (1.11..1 + ulp) leaves the low bits zero, which is
        // already the correctly shifted mantissa of 1.0.
        mant_r = {1'b0, mant} + (ManWidth + 1)'(rnd_up);
        exp_sum = {2'b00, exp_a} + {2'b00, exp_b}
                + EW'(prod[ProdWidth-1]) + EW'(mant_r[ManWidth])
                - EW'(Bias);
        unf = exp_sum[EW-1] | (exp_sum == '0);
        ovf = ~exp_sum[EW-1] & (exp_sum >= EW'(EMax));
    end

    // ---------------- result selection ----------------
    logic [DataWidth-1:0] res_d;
    logic [3:0]           flg_d;
    logic                 inv_op;

    assign inv_op = (inf_a & zero_b) | (zero_a & inf_b);

    always_comb begin
        res_d = '0;
        flg_d = '0;
        if (nan_a | nan_b | inv_op) begin
            res_d = {1'b0, {ExpWidth{1'b1}}, 1'b1, {(ManWidth-1){1'b0}}};
            flg_d = {inv_op | snan, 3'b000};
        end else if (inf_a | inf_b) begin
            res_d = {sign_p, {ExpWidth{1'b1}}, {ManWidth{1'b0}}};
        end else if (zero_a | zero_b) begin
            res_d = {sign_p, {(DataWidth-1){1'b0}}};
        end else if (ovf) begin
            res_d = {sign_p, {ExpWidth{1'b1}}, {ManWidth{1'b0}}};
            flg_d = 4'b0101;
        end else if (unf) begin
            res_d = {sign_p, {(DataWidth-1){1'b0}}};
            flg_d = 4'b0011;
        end else begin
            res_d = {sign_p, exp_sum[ExpWidth-1:0], mant_r[ManWidth-1:0]};
            flg_d = {3'b000, guard | sticky};
        end
    end

    // ---------------- elastic pipeline ----------------
    logic [Latency-1:0]  vld;
    logic [Latency-1:0]  en;
    logic [DataWidth-1:0] res_q [Latency];
    logic [TagWidth-1:0]  tag_q [Latency];
    logic [3:0]           flg_q [Latency];

    // Stage k may load when it is empty or its content moves on; this
    // ripples back from out_ready_i so bubbles collapse.
    always_comb begin
        logic ok;
        ok = out_ready_i;
        en = '0;
        for (int k = int'(Latency) - 1; k >= 0; k--) begin
            ok    = ok | ~vld[k];
            en[k] = ok;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(Latency); k++) begin
                vld[k]   <= 1'b0;
                res_q[k] <= '0;
                tag_q[k] <= '0;
                flg_q[k] <= '0;
            end
        end else begin
            if (en[0]) begin
                vld[0] <= in_valid_i;
                if (in_valid_i) begin
                    res_q[0] <= res_d;
                    tag_q[0] <= tag_i;
                    flg_q[0] <= flg_d;
                end
            end
            for (int k = 1; k < int'(Latency); k++) begin
                if (en[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        res_q[k] <= res_q[k-1];
                        tag_q[k] <= tag_q[k-1];
                        flg_q[k] <= flg_q[k-1];
                    end
                end
            end
        end
    end

    assign in_ready_o  = en[0];
    assign out_valid_o = vld[Latency-1];
    assign result_o    = res_q[Latency-1];
    assign tag_o       = tag_q[Latency-1];
    assign flags_o     = flg_q[Latency-1];

endmodule
